// File: rtl/chromosome_evaluation_scheduler.sv
// Walks one GA generation through the chromosome processor, reduces error sums to fitness,
// tracks the best chromosome. Optional CHROM_SCHED_EARLY_STOP_EN ends a generation on zero error.
module chromosome_evaluation_scheduler #(
    parameter int unsigned POP_SIZE    = 16,
    parameter int unsigned LOAD_CYCLES = 2,
    localparam int unsigned IDX_W      = $clog2(POP_SIZE)
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             iStartGeneration,
    input  logic             iGenerationAck,
    output logic             oGenerationDone,
    output logic [IDX_W-1:0] oChromIndex,
    output logic             oStartProcessing,
    input  logic             iReadyToProcess,
    input  logic             iDoneProcessing,
    output logic             oDoneProcessingFeedback,
    input  logic [255:0]     iErrorSums,
    output logic             oFitnessWrite,
    output logic [IDX_W-1:0] oFitnessAddr,
    output logic [31:0]      oFitnessData,
    output logic [IDX_W-1:0] oBestIndex,
    output logic [31:0]      oBestError,
    output logic [15:0]      oGenerationCount,
    output logic             oEarlyStop,
    output logic             oBusy
);

    localparam int unsigned LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle, StLoad, StStart, StWaitDone, StRecord, StFeedback, StNext, StGenDone
    } state_t;

    state_t         state;
    logic [LCW-1:0] loadCnt;
    logic [31:0]    total;
    logic           idleFb;
    logic [34:0]    sumWide;
    logic           earlyStopQ;

    always_comb begin
        sumWide = '0;
        for (int k = 0; k < 8; k++) begin
            sumWide = sumWide + 35'(iErrorSums[32*k +: 32]);
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state            <= StIdle;
            loadCnt          <= '0;
            total            <= '0;
            idleFb           <= 1'b0;
            earlyStopQ       <= 1'b0;
            oChromIndex      <= '0;
            oBestIndex       <= '0;
            oBestError       <= 32'hFFFF_FFFF;
            oGenerationCount <= '0;
        end else begin
            idleFb <= 1'b0;
            unique case (state)
                StIdle: begin
                    // Stale DONE left over from a reset mid-run: release it with a single pulse.
                    if (iDoneProcessing) begin
                        idleFb <= ~idleFb;
                    end else if (iStartGeneration) begin
                        oChromIndex <= '0;
                        oBestError  <= 32'hFFFF_FFFF;
                        oBestIndex  <= '0;
                        earlyStopQ  <= 1'b0;
                        loadCnt     <= '0;
                        state       <= StLoad;
                    end
                end
                StLoad: begin
                    if (loadCnt == LCW'(LOAD_CYCLES - 1)) begin
                        state <= StStart;
                    end else begin
                        loadCnt <= loadCnt + 1'b1;
                    end
                end
                StStart: begin
                    if (iReadyToProcess) state <= StWaitDone;
                end
                StWaitDone: begin
                    if (iDoneProcessing) begin
                        total <= (sumWide[34:32] != 3'b000) ? 32'hFFFF_FFFF : sumWide[31:0];
                        state <= StRecord;
                    end
                end
                StRecord: begin
                    if (total < oBestError) begin
                        oBestError <= total;
                        oBestIndex <= oChromIndex;
                    end
`ifdef CHROM_SCHED_EARLY_STOP_EN
                    if (total == 32'd0) earlyStopQ <= 1'b1;
`endif
                    state <= StFeedback;
                end
                StFeedback: begin
                    if (earlyStopQ) begin
                        oGenerationCount <= oGenerationCount + 16'd1;
                        state            <= StGenDone;
                    end else begin
                        state <= StNext;
                    end
                end
                StNext: begin
                    if (oChromIndex == IDX_W'(POP_SIZE - 1)) begin
                        oGenerationCount <= oGenerationCount + 16'd1;
                        state            <= StGenDone;
                    end else begin
                        oChromIndex <= oChromIndex + 1'b1;
                        loadCnt     <= '0;
                        state       <= StLoad;
                    end
                end
                StGenDone: begin
                    if (iGenerationAck) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign oStartProcessing        = (state == StStart);
    assign oFitnessWrite           = (state == StRecord);
    assign oFitnessAddr            = oChromIndex;
    assign oFitnessData            = total;
    assign oGenerationDone         = (state == StGenDone);
    assign oBusy                   = (state != StIdle);
    assign oDoneProcessingFeedback = (state == StFeedback) | idleFb;
`ifdef CHROM_SCHED_EARLY_STOP_EN
    assign oEarlyStop = earlyStopQ;
`else
    assign oEarlyStop = 1'b0;
`endif

endmodule

// File: tb/tb_chromosome_evaluation_scheduler.sv
// Directed bench for chromosome_evaluation_scheduler with a small behavioural processor model.
module tb_chromosome_evaluation_scheduler;

    localparam int unsigned POP = 4;

    logic         clk = 1'b0;
    logic         iReset = 1'b1;
    logic         iStartGeneration = 1'b0;
    logic         iGenerationAck = 1'b0;
    logic         oGenerationDone;
    logic [1:0]   oChromIndex;
    logic         oStartProcessing;
    logic         iReadyToProcess;
    logic         iDoneProcessing;
    logic         oDoneProcessingFeedback;
    logic [255:0] iErrorSums;
    logic         oFitnessWrite;
    logic [1:0]   oFitnessAddr;
    logic [31:0]  oFitnessData;
    logic [1:0]   oBestIndex;
    logic [31:0]  oBestError;
    logic [15:0]  oGenerationCount;
    logic         oEarlyStop;
    logic         oBusy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chromosome_evaluation_scheduler #(.POP_SIZE(POP), .LOAD_CYCLES(2)) dut (
        .iClock(clk), .iReset(iReset),
        .iStartGeneration(iStartGeneration), .iGenerationAck(iGenerationAck),
        .oGenerationDone(oGenerationDone), .oChromIndex(oChromIndex),
        .oStartProcessing(oStartProcessing), .iReadyToProcess(iReadyToProcess),
        .iDoneProcessing(iDoneProcessing), .oDoneProcessingFeedback(oDoneProcessingFeedback),
        .iErrorSums(iErrorSums), .oFitnessWrite(oFitnessWrite), .oFitnessAddr(oFitnessAddr),
        .oFitnessData(oFitnessData), .oBestIndex(oBestIndex), .oBestError(oBestError),
        .oGenerationCount(oGenerationCount), .oEarlyStop(oEarlyStop), .oBusy(oBusy)
    );

    // Processor model: 0 idle, 1 busy, 2 done; not reset by the scheduler.
    logic [255:0] sumTable [POP];
    int           procLatency = 3;
    int           holdLimit = 0;
    int           pState = 0;
    int           lat = 0;
    int           stallSeen = 0;
    logic [1:0]   curIdx = 2'd0;
    int           runCnt [POP] = '{0, 0, 0, 0};

    assign iReadyToProcess = (pState == 0) && (stallSeen >= holdLimit);
    assign iDoneProcessing = (pState == 2);
    assign iErrorSums      = sumTable[curIdx];

    always @(posedge clk) begin
        case (pState)
            0: if (oStartProcessing) begin
                if (stallSeen < holdLimit) begin
                    stallSeen <= stallSeen + 1;
                end else begin
                    stallSeen         <= 0;
                    pState            <= 1;
                    lat               <= procLatency;
                    curIdx            <= oChromIndex;
                    runCnt[oChromIndex] <= runCnt[oChromIndex] + 1;
                end
            end
            1: if (lat <= 1) pState <= 2; else lat <= lat - 1;
            default: if (oDoneProcessingFeedback) pState <= 0;
        endcase
    end

    // Monitors (append-only; tests work on deltas).
    logic [1:0]  wrAddr [$];
    logic [31:0] wrData [$];
    int          fbCount = 0;
    int          startHigh [POP] = '{0, 0, 0, 0};

    always @(negedge clk) begin
        if (oFitnessWrite) begin
            wrAddr.push_back(oFitnessAddr);
            wrData.push_back(oFitnessData);
        end
        if (oDoneProcessingFeedback) fbCount <= fbCount + 1;
        if (oStartProcessing) startHigh[oChromIndex] <= startHigh[oChromIndex] + 1;
    end

    function automatic logic [255:0] mk(input logic [31:0] a, input logic [31:0] b);
        mk          = '0;
        mk[31:0]    = a;
        mk[255:224] = b;
    endfunction

    task automatic start_gen();
        @(negedge clk) iStartGeneration = 1'b1;
        @(negedge clk) iStartGeneration = 1'b0;
    endtask

    task automatic wait_gen_done(output bit timedOut);
        timedOut = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (oGenerationDone) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic ack_gen();
        @(negedge clk) iGenerationAck = 1'b1;
        @(negedge clk) iGenerationAck = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        iReset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (oBusy !== 1'b0 || oGenerationDone !== 1'b0 || oStartProcessing !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b start=%b, need 0 0 0",
                     oBusy, oGenerationDone, oStartProcessing);
        end
        checks++;
        if (oBestError !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_best_error: got %h need ffffffff", oBestError);
        end
        checks++;
        if (oGenerationCount !== 16'd0 || oChromIndex !== 2'd0 || oBestIndex !== 2'd0
            || oFitnessWrite !== 1'b0 || oEarlyStop !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: cnt=%0d idx=%0d best=%0d wr=%b es=%b, need all 0",
                     oGenerationCount, oChromIndex, oBestIndex, oFitnessWrite, oEarlyStop);
        end
        iReset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int  base;
        bit  to;
        for (int i = 0; i < POP; i++) sumTable[i] = mk(32'd1, 32'd0);
        base = wrAddr.size();
        start_gen();
        wait_gen_done(to);
        checks++;
        if (to || wrAddr.size() - base != 4) begin
            errors++;
            $display("FAIL basic_writes: timeout=%b writes=%0d need 4", to, wrAddr.size() - base);
        end
        for (int i = 0; i < POP; i++) begin
            checks++;
            if (wrAddr[base+i] !== 2'(i) || wrData[base+i] !== 32'd1) begin
                errors++;
                $display("FAIL basic_entry%0d: addr=%0d data=%0d need %0d 1",
                         i, wrAddr[base+i], wrData[base+i], i);
            end
        end
        checks++;
        if (oBestIndex !== 2'd0 || oBestError !== 32'd1 || oGenerationCount !== 16'd1
            || oEarlyStop !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: best=%0d err=%0d cnt=%0d es=%b need 0 1 1 0",
                     oBestIndex, oBestError, oGenerationCount, oEarlyStop);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (oGenerationDone !== 1'b1) begin
            errors++;
            $display("FAIL basic_done_held: got %b need 1", oGenerationDone);
        end
        ack_gen();
        checks++;
        if (oGenerationDone !== 1'b0 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_ack: done=%b busy=%b need 0 0", oGenerationDone, oBusy);
        end
    endtask

    task automatic test_tie();
        int base;
        bit to;
        sumTable[0] = mk(32'd4, 32'd6);
        sumTable[1] = mk(32'd1, 32'd2);
        sumTable[2] = mk(32'd3, 32'd0);
        sumTable[3] = mk(32'd0, 32'd7);
        base = wrAddr.size();
        start_gen();
        wait_gen_done(to);
        checks++;
        if (to || wrData[base] !== 32'd10 || wrData[base+3] !== 32'd7) begin
            errors++;
            $display("FAIL tie_data: timeout=%b d0=%0d d3=%0d need 10 7",
                     to, wrData[base], wrData[base+3]);
        end
        checks++;
        if (oBestIndex !== 2'd1 || oBestError !== 32'd3 || oGenerationCount !== 16'd2) begin
            errors++;
            $display("FAIL tie_best: best=%0d err=%0d cnt=%0d need 1 3 2",
                     oBestIndex, oBestError, oGenerationCount);
        end
        ack_gen();
    endtask

    task automatic test_saturation();
        int base;
        bit to;
        for (int i = 0; i < 3; i++) sumTable[i] = {8{32'hFFFF_FFFF}};
        sumTable[3] = mk(32'h8000_0000, 32'h7FFF_FFFE);
        base = wrAddr.size();
        start_gen();
        wait_gen_done(to);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (to || wrData[base+i] !== 32'hFFFF_FFFF) begin
                errors++;
                $display("FAIL sat_entry%0d: data=%h need ffffffff", i, wrData[base+i]);
            end
        end
        checks++;
        if (oBestIndex !== 2'd3 || oBestError !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL sat_best: best=%0d err=%h need 3 fffffffe", oBestIndex, oBestError);
        end
        ack_gen();
    endtask

    task automatic test_ready_stall();
        int sh0;
        int rc [POP];
        bit to;
        for (int i = 0; i < POP; i++) sumTable[i] = mk(32'd2, 32'd0);
        sh0 = startHigh[0];
        for (int i = 0; i < POP; i++) rc[i] = runCnt[i];
        holdLimit = 50;
        start_gen();
        wait_gen_done(to);
        holdLimit = 0;
        checks++;
        if (to || startHigh[0] - sh0 != 51) begin
            errors++;
            $display("FAIL stall_start_cycles: timeout=%b got %0d need 51", to, startHigh[0] - sh0);
        end
        for (int i = 0; i < POP; i++) begin
            checks++;
            if (runCnt[i] - rc[i] != 1) begin
                errors++;
                $display("FAIL stall_runs%0d: got %0d need 1", i, runCnt[i] - rc[i]);
            end
        end
        ack_gen();
    endtask

    task automatic test_reset_midrun();
        int  fb0;
        int  base;
        bit  to;
        bit  seen;
        procLatency = 8;
        start_gen();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pState == 1) begin
                seen = 1'b1;
                break;
            end
        end
        iReset = 1'b1;
        @(negedge clk);
        checks++;
        if (!seen || oBusy !== 1'b0 || oBestError !== 32'hFFFF_FFFF || oGenerationCount !== 16'd0) begin
            errors++;
            $display("FAIL midrun_reset_vals: seen=%b busy=%b err=%h cnt=%0d need 1 0 ffffffff 0",
                     seen, oBusy, oBestError, oGenerationCount);
        end
        fb0 = fbCount;
        iReset = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (pState == 2) begin
                to = 1'b0;
                break;
            end
        end
        repeat (6) @(negedge clk);
        checks++;
        if (to || fbCount - fb0 != 1 || pState != 0 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_stale_fb: timeout=%b pulses=%0d pstate=%0d busy=%b need 0 1 0 0",
                     to, fbCount - fb0, pState, oBusy);
        end
        procLatency = 3;
        for (int i = 0; i < POP; i++) sumTable[i] = mk(32'd5, 32'd0);
        base = wrAddr.size();
        start_gen();
        wait_gen_done(to);
        checks++;
        if (to || wrAddr.size() - base != 4 || oGenerationCount !== 16'd1) begin
            errors++;
            $display("FAIL midrun_next_gen: timeout=%b writes=%0d cnt=%0d need 0 4 1",
                     to, wrAddr.size() - base, oGenerationCount);
        end
        ack_gen();
    endtask

    task automatic test_early_stop();
        int base;
        bit to;
        int expWrites;
        logic expEs;
`ifdef CHROM_SCHED_EARLY_STOP_EN
        expWrites = 2;
        expEs     = 1'b1;
`else
        expWrites = 4;
        expEs     = 1'b0;
`endif
        sumTable[0] = mk(32'd5, 32'd0);
        sumTable[1] = '0;
        sumTable[2] = mk(32'd4, 32'd0);
        sumTable[3] = mk(32'd0, 32'd9);
        base = wrAddr.size();
        start_gen();
        wait_gen_done(to);
        checks++;
        if (to || wrAddr.size() - base != expWrites || wrAddr[base+1] !== 2'd1) begin
            errors++;
            $display("FAIL early_writes: timeout=%b writes=%0d need %0d",
                     to, wrAddr.size() - base, expWrites);
        end
        checks++;
        if (oEarlyStop !== expEs || oBestIndex !== 2'd1 || oBestError !== 32'd0) begin
            errors++;
            $display("FAIL early_result: es=%b best=%0d err=%0d need %b 1 0",
                     oEarlyStop, oBestIndex, oBestError, expEs);
        end
        ack_gen();
    endtask

    initial begin
        for (int i = 0; i < POP; i++) sumTable[i] = '0;
        test_reset();
        test_basic();
        test_tie();
        test_saturation();
        test_ready_stall();
        test_reset_midrun();
        test_early_stop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chromosome_evaluation_scheduler.md
Name: chromosome_evaluation_scheduler

Overview:
- Sequences one generation's population through the chromosome processing FSM, one chromosome at a time.
- Drives the processor's start/done-feedback handshake and selects the chromosome index presented to the population memory.
- Reduces the 8 per-output error sums to one fitness value and writes it to a fitness table.
- Tracks the best (lowest-error) chromosome and reports generation completion to the GA host logic.

Parameters:
- POP_SIZE, 16, chromosomes per generation (≥2).
- LOAD_CYCLES, 2, cycles waited after index change for chromosome description to settle from population memory (≥1).
- IDX_W, $clog2(POP_SIZE), localparam, index width.

Ports:
- iClock  in  1  system clock
- iReset  in  1  asynchronous active-high reset
- iStartGeneration  in  1  level; begin a generation when IDLE
- iGenerationAck  in  1  host acknowledge of oGenerationDone
- oGenerationDone  out  1  high while in GEN_DONE
- oChromIndex  out  IDX_W  population memory read index
- oStartProcessing  out  1  to processor start input
- iReadyToProcess  in  1  processor in IDLE
- iDoneProcessing  in  1  processor in DONE
- oDoneProcessingFeedback  out  1  to processor done-feedback input
- iErrorSums  in  256  eight 32-bit error sums, sum k at bits [32k+31:32k]
- oFitnessWrite  out  1  one-cycle fitness table write strobe
- oFitnessAddr  out  IDX_W  fitness table address
- oFitnessData  out  32  saturated total error
- oBestIndex  out  IDX_W  index of lowest-error chromosome this generation
- oBestError  out  32  its total error
- oGenerationCount  out  16  completed generations
- oEarlyStop  out  1  generation ended on a zero-error chromosome
- oBusy  out  1  state != IDLE

Behaviour:
- Reset (async, iReset=1): state IDLE; all outputs 0 except oBestError=32'hFFFFFFFF; internal counters 0. Processor is not reset by this block.
- States: IDLE, LOAD, START, WAIT_DONE, RECORD, FEEDBACK, NEXT, GEN_DONE.
- IDLE:
  - If iDoneProcessing=1, assert oDoneProcessingFeedback for that cycle. This is stale-DONE recovery after reset mid-run.
  - Else if iStartGeneration=1: oChromIndex←0, oBestError←FFFFFFFF, oBestIndex←0, oEarlyStop←0, load counter←0, go LOAD.
  - iStartGeneration outside IDLE is ignored.
- LOAD: count LOAD_CYCLES cycles, then go START.
- START:
  - oStartProcessing=1 (Moore).
  - Transition to WAIT_DONE on the edge where iReadyToProcess=1. Start is therefore high exactly one cycle when the processor is ready.
  - Stays in START indefinitely if not ready.
- WAIT_DONE: on iDoneProcessing=1, register total = Σ iErrorSums[k] in 35-bit arithmetic, saturated to 32'hFFFFFFFF if ≥2^32; go RECORD.
- RECORD:
  - oFitnessWrite=1, oFitnessAddr=oChromIndex, oFitnessData=total.
  - If total < oBestError (strict), update best index/error. Ties keep the lower index.
  - Go FEEDBACK.
- FEEDBACK: oDoneProcessingFeedback=1 for exactly one cycle (processor is guaranteed still in DONE); go NEXT.
- NEXT: if oChromIndex==POP_SIZE-1 go GEN_DONE, else oChromIndex+1, go LOAD.
- GEN_DONE:
  - On entry, oGenerationCount+1; wraps FFFF→0.
  - oGenerationDone=1 until iGenerationAck=1, then IDLE.
  - Ack seen in the same cycle as entry is honoured on the next cycle.
- Timing:
  - All outputs registered or decoded from the state register; no input-to-output combinational path.
  - Per-chromosome overhead outside processor time: LOAD_CYCLES + 4 cycles.

Optional Feature:
- Macro: CHROM_SCHED_EARLY_STOP_EN
- Defined:
  - A total of 0 in RECORD sets oEarlyStop=1.
  - FEEDBACK then proceeds to GEN_DONE instead of NEXT, skipping remaining chromosomes.
  - Unevaluated fitness entries are not written.
- Undefined: all POP_SIZE chromosomes are always evaluated; oEarlyStop is tied 0.

Test Plan:
- Reset, then iStartGeneration=1 with processor model returning sums {1,0,…,0} for every chromosome (POP_SIZE=4) -> 4 fitness writes, addr 0..3, data 1; oBestIndex=0; oGenerationCount=1; oGenerationDone held until ack.
- Sums per index: 10, 3, 3, 7 -> oBestIndex=1, oBestError=3 (tie keeps lower index).
- Eight sums of 32'hFFFFFFFF -> oFitnessData=32'hFFFFFFFF (saturation).
- Processor holds iReadyToProcess=0 for 50 cycles -> oStartProcessing stays high 50 cycles, then 1 start pulse; exactly one processor run per index.
- Assert iReset during WAIT_DONE while the processor later reaches DONE -> scheduler IDLE, outputs at reset values; one oDoneProcessingFeedback pulse issued from IDLE; next generation completes normally.
- With CHROM_SCHED_EARLY_STOP_EN, index 1 returns all-zero sums (POP_SIZE=4) -> writes for 0,1 only; oEarlyStop=1; oBestIndex=1, oBestError=0. Without the macro: 4 writes and oEarlyStop=0.
